// File: rtl/stacker_fsm_param.sv
// rtl/stacker_fsm_param.sv - parametrised stacker game controller; STACKER_WRAP_EN selects circular moves instead of bounce
module stacker_fsm_param #(
    parameter int COLS          = 8,
    parameter int ROWS          = 8,
    parameter int IDX_W         = 3,
    parameter int INIT_WIDTH    = 3,
    parameter int TICK_DIV_INIT = 4,
    parameter int DIV_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn,
    input  logic             step_tick,
    output logic [COLS-1:0]  val,
    output logic [IDX_W-1:0] row_index,
    output logic             write_strobe,
    output logic             clr_array,
    output logic [2:0]       state,
    output logic [DIV_W-1:0] move_div
);

    localparam logic [2:0] S_INIT   = 3'b000;
    localparam logic [2:0] S_TRACE  = 3'b001;
    localparam logic [2:0] S_CHECK  = 3'b010;
    localparam logic [2:0] S_UPDATE = 3'b100;
    localparam logic [2:0] S_WIN    = 3'b101;
    localparam logic [2:0] S_LOSE   = 3'b111;

    localparam logic [COLS-1:0]  INIT_PAT = ~({COLS{1'b1}} >> INIT_WIDTH);
    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(TICK_DIV_INIT);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [COLS-1:0]  r_val;
    logic [IDX_W-1:0] r_row_index;
    logic             r_write_strobe;
    logic [DIV_W-1:0] r_move_div;
    logic [DIV_W-1:0] r_tick_cnt;
    logic [COLS-1:0]  r_cur_row;
    logic [COLS-1:0]  r_prev_row;
    logic [COLS-1:0]  r_locked;
    logic [COLS-1:0]  r_lock_raw;
    logic             r_dir_msb;
    logic [COLS-1:0]  w_moved;
    logic             w_dir_next;
    logic [DIV_W:0]   w_tick_inc;
    logic [COLS-1:0]  w_lock_now;

    assign val          = r_val;
    assign row_index    = r_row_index;
    assign write_strobe = r_write_strobe;
    assign state        = r_state;
    assign move_div     = r_move_div;

    assign w_tick_inc = {1'b0, r_tick_cnt} + (DIV_W+1)'(1);
    assign w_lock_now = r_cur_row & r_prev_row;

    // Pattern after one move of the sweeping block, and the direction that follows it
    always_comb begin
        w_moved    = r_cur_row;
        w_dir_next = r_dir_msb;
`ifdef STACKER_WRAP_EN
        w_moved = {r_cur_row[0], r_cur_row[COLS-1:1]};
`else
        if (r_dir_msb) begin
            if (r_cur_row[COLS-1]) begin
                w_dir_next = 1'b0;
                if (!r_cur_row[0]) w_moved = r_cur_row >> 1;
            end else begin
                w_moved = r_cur_row << 1;
            end
        end else begin
            if (r_cur_row[0]) begin
                w_dir_next = 1'b1;
                if (!r_cur_row[COLS-1]) w_moved = r_cur_row << 1;
            end else begin
                w_moved = r_cur_row >> 1;
            end
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_INIT;
        else       r_state <= w_next_state;
    end

    // Next-state decision
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:   w_next_state = S_TRACE;
            S_TRACE:  if (btn) w_next_state = S_CHECK;
            S_CHECK: begin
                if (r_locked == '0)               w_next_state = S_LOSE;
                else if (r_row_index == LAST_ROW) w_next_state = S_WIN;
                else                              w_next_state = S_UPDATE;
            end
            S_UPDATE: if (r_locked[COLS-1]) w_next_state = S_TRACE;
            S_WIN, S_LOSE: if (btn) w_next_state = S_INIT;
            default:  w_next_state = S_INIT;
        endcase
    end

    // Combinational outputs
    always_comb begin
        clr_array = (r_state == S_INIT);
    end

    // Game datapath: sweep, lock, alignment, speed-up and row writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_val          <= '0;
            r_row_index    <= '0;
            r_write_strobe <= 1'b0;
            r_move_div     <= DIV_INIT;
            r_tick_cnt     <= '0;
            r_cur_row      <= INIT_PAT;
            r_prev_row     <= '1;
            r_locked       <= '0;
            r_lock_raw     <= '0;
            r_dir_msb      <= 1'b0;
        end else begin
            r_write_strobe <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_row_index    <= '0;
                    r_move_div     <= DIV_INIT;
                    r_tick_cnt     <= '0;
                    r_cur_row      <= INIT_PAT;
                    r_prev_row     <= '1;
                    r_locked       <= '0;
                    r_lock_raw     <= '0;
                    r_dir_msb      <= 1'b0;
                    r_val          <= INIT_PAT;
                    r_write_strobe <= 1'b1;
                end
                S_TRACE: begin
                    if (btn) begin
                        r_locked       <= w_lock_now;
                        r_lock_raw     <= w_lock_now;
                        r_val          <= w_lock_now;
                        r_write_strobe <= 1'b1;
                        r_tick_cnt     <= '0;
                    end else if (step_tick) begin
                        if (w_tick_inc == {1'b0, r_move_div}) begin
                            r_tick_cnt     <= '0;
                            r_cur_row      <= w_moved;
                            r_dir_msb      <= w_dir_next;
                            r_val          <= w_moved;
                            r_write_strobe <= 1'b1;
                        end else begin
                            r_tick_cnt <= w_tick_inc[DIV_W-1:0];
                        end
                    end
                end
                S_CHECK: begin
                    if (r_locked != '0 && r_row_index != LAST_ROW) begin
                        r_row_index <= r_row_index + IDX_W'(1);
                        if (r_move_div > DIV_ONE) r_move_div <= r_move_div - DIV_ONE;
                        else                      r_move_div <= DIV_ONE;
                    end
                end
                S_UPDATE: begin
                    if (!r_locked[COLS-1]) begin
                        r_locked <= r_locked << 1;
                    end else begin
                        r_prev_row     <= r_lock_raw;
                        r_cur_row      <= r_locked;
                        r_dir_msb      <= 1'b0;
                        r_tick_cnt     <= '0;
                        r_val          <= r_locked;
                        r_write_strobe <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/stacker_fsm_param.md
Name: stacker_fsm_param

Overview:
- Parametrised successor to the 8x8 stacker game controller.
- A block of lit cells sweeps across a row of COLS cells. A button press locks it, and the locked row is the AND of the sweeping pattern with the row below it.
- Play climbs ROWS rows; step speed increases per locked row.
- Sits between the debounced button / step-tick generator and the display row array. Drives row writes via val/row_index/write_strobe.

Parameters:
- COLS, 8, cells per row (val width); >= 2.
- ROWS, 8, rows to climb to win; >= 2.
- IDX_W, 3, row_index width; 2**IDX_W >= ROWS.
- INIT_WIDTH, 3, lit cells in the starting block, MSB-aligned; 1..COLS.
- TICK_DIV_INIT, 4, step_tick pulses per move on row 0; >= 1.
- DIV_W, 4, move-divider counter width; must hold TICK_DIV_INIT.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn  in  1  debounced one-cycle press pulse.
- step_tick  in  1  one-cycle movement strobe.
- val  out  COLS  row pattern to write.
- row_index  out  IDX_W  row being written/played.
- write_strobe  out  1  one-cycle write enable for val at row_index.
- clr_array  out  1  clear display array; high while state==INIT.
- state  out  3  current state code.
- move_div  out  DIV_W  current step_tick pulses per move.

Behaviour:
- State codes: INIT=000, TRACE=001, CHECK=010, UPDATE=100, WIN=101, LOSE=111. Other codes go to INIT next cycle.
- Reset (async) sets:
  - state=INIT, val=0, row_index=0, write_strobe=0, move_div=TICK_DIV_INIT.
  - Internal: cur_row = INIT_WIDTH ones MSB-aligned, prev_row = all ones, tick_cnt=0, dir=toward-LSB.
- Reset mid-operation discards all progress. Reset while btn is high has no effect beyond reset.
- write_strobe defaults to 0 every cycle; it pulses for exactly one cycle where stated below.
- INIT (1 cycle):
  - clr_array=1; reload all reset values.
  - val <= initial pattern, write_strobe=1, go to TRACE.
- TRACE:
  - btn has priority over step_tick in the same cycle.
  - On btn:
    - locked <= cur_row & prev_row; val <= locked; write_strobe=1.
    - tick_cnt <= 0; go to CHECK.
  - Else on step_tick:
    - tick_cnt+1. When it reaches move_div: tick_cnt <= 0 and make one move.
    - A move writes the new pattern to val with write_strobe=1.
  - Bounce (default) move rule:
    - Moving toward-MSB with bit COLS-1 set: flip dir, shift toward LSB.
    - Moving toward-LSB with bit 0 set: flip dir, shift toward MSB.
    - Otherwise shift by 1 in dir. Bits are never lost.
- CHECK (1 cycle):
  - locked==0 -> LOSE.
  - Else row_index==ROWS-1 -> WIN.
  - Else:
    - row_index+1.
    - move_div <= max(move_div-1, 1).
    - Go to UPDATE.
- UPDATE (1..COLS cycles):
  - While locked[COLS-1]==0: locked <<= 1, one bit per cycle.
  - When MSB is set:
    - prev_row <= cur_row's locked value (pre-shift); cur_row <= aligned locked.
    - dir=toward-LSB; val <= aligned locked; write_strobe=1; go to TRACE.
  - prev_row holds the unshifted lock for the AND on the next row.
- WIN / LOSE:
  - Hold; outputs static.
  - btn -> INIT. step_tick ignored.

Optional Feature:
- Macro STACKER_WRAP_EN.
- Defined: moves rotate circularly in dir. The bit leaving one end enters the other; dir never flips.
- Undefined: bounce rule above.
- All other behaviour identical in both builds.

Test Plan:
- Defaults, reset pulse then release -> INIT one cycle (clr_array=1) then TRACE. First strobe: val=8'b11100000, row_index=0, move_div=4.
- 4 step_ticks -> val=01110000. Bounce check:
  - Further moves walk toward the LSB to 00000111.
  - The next move after that -> 00001110 (dir flipped).
- btn immediately in row 0:
  - Strobe val=11100000, CHECK.
  - UPDATE aligned in 1 cycle, strobe val=11100000 at row_index=1, move_div=3.
- Row 1: 3 ticks -> 01110000; btn -> strobe val=01100000.
  - UPDATE shifts 1 cycle -> strobe val=11000000 at row_index=2.
- Miss: at row 1, cur_row=00000111, prev=11100000, btn -> LOSE (111). Then btn -> INIT, clr_array=1.
- Eight immediate presses -> WIN (101) with row_index=7 and move_div floor at 1.
  - Async reset asserted mid-UPDATE -> state=000 at once, no write_strobe.
  - STACKER_WRAP_EN build: 00000001 moving toward-LSB -> 10000000.
